// File: rtl/uart_rx_frame.sv
// ----------------------------------------------------------------------------
// uart_rx_frame
// Oversampling UART receiver. A frame is a start bit, DATA_WIDTH data bits
// sent LSB first, an optional parity bit and one stop bit. Each bit is
// resolved by a 2-of-3 majority vote of samples taken around mid-bit.
// A good frame updates P_DATA and pulses data_valid for one cycle. A bad
// frame pulses parity_error and/or stop_error and leaves P_DATA unchanged.
//
// Ports
//   CLK          oversampling clock (Prescale x baud)
//   RST          asynchronous reset, active-low
//   RX_IN        serial line, idle high
//   PAR_EN       1 = frame carries a parity bit (captured at start of frame)
//   PAR_TYP      0 = even, 1 = odd parity (captured at start of frame)
//   Prescale     oversampling ratio: 16 or 32, any other value means 8
//   P_DATA       last good received word
//   data_valid   one-cycle pulse when P_DATA is updated
//   parity_error one-cycle pulse on parity mismatch
//   stop_error   one-cycle pulse on a stop bit sampled as 0
//
// Build option
//   UART_RX_SYNC_EN  when defined, RX_IN goes through a 2-flop synchroniser
//                    (reset value 1) first, which adds 2 CLK of latency.
//                    When undefined, RX_IN must already be synchronous to CLK.
// ----------------------------------------------------------------------------
module uart_rx_frame #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error
);

    localparam int BC_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // 2-of-3 majority vote of the three mid-bit samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Parity bit the transmitter appends: XOR for even, XNOR for odd
    function automatic logic par_calc(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return odd ? ~^d : ^d;
    endfunction

    logic                  w_rx;
    logic [5:0]            w_presc_dec;
    logic [5:0]            w_half;
    logic                  w_bit_end;
    logic                  w_samp0;
    logic                  w_samp1;
    logic                  w_resolve;
    logic                  w_maj;

    state_t                r_state;
    logic [5:0]            r_presc;
    logic [5:0]            r_edge_cnt;
    logic [BC_W-1:0]       r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_s0;
    logic                  r_s1;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic                  r_par_bad;
    logic                  r_stop_ok;

`ifdef UART_RX_SYNC_EN
    logic [1:0] r_sync;

    // Two-flop synchroniser; idles high so reset never looks like a start bit
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], RX_IN};
        end
    end

    assign w_rx = r_sync[1];
`else
    assign w_rx = RX_IN;
`endif

    // Effective oversampling ratio: only 16 and 32 are honoured, else 8
    always_comb begin
        w_presc_dec = 6'd8;
        if (Prescale == PRESCALE_W'(16)) begin
            w_presc_dec = 6'd16;
        end else if (Prescale == PRESCALE_W'(32)) begin
            w_presc_dec = 6'd32;
        end else begin
            w_presc_dec = 6'd8;
        end
    end

    // Sample points around mid-bit and the bit-end marker for the held ratio
    always_comb begin
        w_half    = r_presc >> 1;
        w_bit_end = (r_edge_cnt == (r_presc - 6'd1));
        w_samp0   = (r_edge_cnt == (w_half - 6'd1));
        w_samp1   = (r_edge_cnt == w_half);
        w_resolve = (r_edge_cnt == (w_half + 6'd1));
        w_maj     = maj3(r_s0, r_s1, w_rx);
    end

    // Receive FSM with counters, sample capture and registered frame result
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state      <= IDLE;
            r_presc      <= 6'd8;
            r_edge_cnt   <= 6'd0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_s0         <= 1'b1;
            r_s1         <= 1'b1;
            r_par_en     <= 1'b0;
            r_par_typ    <= 1'b0;
            r_par_bad    <= 1'b0;
            r_stop_ok    <= 1'b1;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;

            if (r_state != IDLE) begin
                r_edge_cnt <= w_bit_end ? 6'd0 : (r_edge_cnt + 6'd1);
                if (w_samp0) begin
                    r_s0 <= w_rx;
                end
                if (w_samp1) begin
                    r_s1 <= w_rx;
                end
            end

            case (r_state)
                IDLE: begin
                    // Ratio is tracked while idle and frozen once a frame starts
                    r_presc    <= w_presc_dec;
                    r_edge_cnt <= 6'd0;
                    r_bit_cnt  <= '0;
                    if (!w_rx) begin
                        r_state   <= START;
                        r_par_en  <= PAR_EN;
                        r_par_typ <= PAR_TYP;
                        r_par_bad <= 1'b0;
                    end
                end

                START: begin
                    if (w_resolve && w_maj) begin
                        // Start bit did not hold low at mid-bit: treat as glitch
                        r_state    <= IDLE;
                        r_edge_cnt <= 6'd0;
                    end else if (w_bit_end) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                    end
                end

                DATA: begin
                    if (w_resolve) begin
                        r_shift[r_bit_cnt] <= w_maj;
                    end
                    if (w_bit_end) begin
                        if (r_bit_cnt == BC_W'(DATA_WIDTH - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= r_par_en ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + {{(BC_W-1){1'b0}}, 1'b1};
                        end
                    end
                end

                PARITY: begin
                    if (w_resolve && (w_maj != par_calc(r_shift, r_par_typ))) begin
                        r_par_bad <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_state <= STOP;
                    end
                end

                STOP: begin
                    if (w_resolve) begin
                        r_stop_ok <= w_maj;
                    end
                    if (w_bit_end) begin
                        if (r_par_bad || !r_stop_ok) begin
                            parity_error <= r_par_bad;
                            stop_error   <= !r_stop_ok;
                        end else begin
                            P_DATA     <= r_shift;
                            data_valid <= 1'b1;
                        end
                        // Line already low here means the next start bit has begun
                        if (!w_rx) begin
                            r_state   <= START;
                            r_par_en  <= PAR_EN;
                            r_par_typ <= PAR_TYP;
                            r_par_bad <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_edge_cnt <= 6'd0;
                    r_bit_cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_frame
// Directed bench for uart_rx_frame. Frames are serialised by the bench; the
// expected result of every frame is computed from the frame contents and
// pushed to a queue, and a monitor pops and compares on each output pulse.
// ----------------------------------------------------------------------------
module tb_uart_rx_frame;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_error;
    logic       stop_error;

    typedef struct {
        logic [7:0] pd;
        logic       dv;
        logic       pe;
        logic       se;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         failures = 0;
    logic [7:0] last_good = 8'h00;

    uart_rx_frame #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .Prescale(Prescale), .P_DATA(P_DATA), .data_valid(data_valid),
        .parity_error(parity_error), .stop_error(stop_error)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outcome of one frame, derived from what the bench puts on the line
    task automatic push_exp(input logic [7:0] d, input logic pen, input logic typ,
                            input logic pbit, input logic sbit);
        exp_t e;
        logic good_par;
        good_par = !pen || (pbit == (typ ? ~^d : ^d));
        e.pe = !good_par;
        e.se = !sbit;
        if (e.pe || e.se) begin
            e.dv = 1'b0;
            e.pd = last_good;
        end else begin
            e.dv = 1'b1;
            e.pd = d;
            last_good = d;
        end
        q.push_back(e);
    endtask

    task automatic send_bit(input logic b, input int p);
        RX_IN = b;
        repeat (p) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                              input logic pbit, input logic sbit);
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        if (pen) send_bit(pbit, p);
        send_bit(sbit, p);
    endtask

    // Wait (bounded) until every expected result has been seen
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, q.size(), 0);
        repeat (10) @(negedge CLK);
    endtask

    initial begin
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_p_data", P_DATA, 0);
        chk("reset_data_valid", data_valid, 0);
        chk("reset_parity_error", parity_error, 0);
        chk("reset_stop_error", stop_error, 0);
        RST = 1'b1;
        repeat (5) @(negedge CLK);

        fork
            forever begin
                @(negedge CLK);
                if (data_valid || parity_error || stop_error) begin
                    chk("pulse_expected", (q.size() > 0) ? 1 : 0, 1);
                    if (q.size() > 0) begin
                        exp_t e;
                        e = q.pop_front();
                        chk("data_valid", data_valid, e.dv);
                        chk("parity_error", parity_error, e.pe);
                        chk("stop_error", stop_error, e.se);
                        chk("p_data", P_DATA, e.pd);
                    end
                end
            end
        join_none

        // Good even-parity frame at x8
        Prescale = 6'd8; PAR_EN = 1'b1; PAR_TYP = 1'b0;
        push_exp(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
        send_frame(8'hA5, 8, 1'b1, 1'b0, 1'b1);
        RX_IN = 1'b1;
        drain("drain_a5");

        // Odd parity with wrong parity bit at x16
        Prescale = 6'd16; PAR_EN = 1'b1; PAR_TYP = 1'b1;
        push_exp(8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1);
        RX_IN = 1'b1;
        drain("drain_3c_par");

        // Bad stop bit, no parity, x8
        Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        push_exp(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0);
        RX_IN = 1'b1;
        drain("drain_81_stop");

        // Two-cycle low glitch must not produce a frame
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (40) @(negedge CLK);
        chk("glitch_no_output", q.size(), 0);
        push_exp(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1);
        RX_IN = 1'b1;
        drain("drain_55");

        // Back-to-back frames at x32 with no idle gap
        Prescale = 6'd32; PAR_EN = 1'b0;
        push_exp(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        push_exp(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h3C, 32, 1'b0, 1'b0, 1'b1);
        send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b1);
        RX_IN = 1'b1;
        drain("drain_b2b");

        // Reset in the middle of a 0xFF frame, then a clean 0x12 frame
        Prescale = 6'd8;
        send_bit(1'b0, 8);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 8);
        RST = 1'b0;
        last_good = 8'h00;
        RX_IN = 1'b1;
        repeat (2) @(negedge CLK);
        chk("midreset_p_data", P_DATA, 0);
        chk("midreset_data_valid", data_valid, 0);
        RST = 1'b1;
        repeat (40) @(negedge CLK);
        chk("midreset_no_output", q.size(), 0);
        push_exp(8'h12, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1);
        RX_IN = 1'b1;
        drain("drain_12");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
